// File: rtl/spi_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_parser_if
// Brief    : Byte-strobe input, response byte and register-bus signals of the
//            SPI command parser.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_cmd_parser_if #(
    parameter int ADDR_W = 8
);
    logic              cs_n;
    logic [7:0]        rec_data;
    logic              rec_valid;
    logic [7:0]        response_data;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [7:0]        reg_rdata;
    logic              cmd_err;
    logic              busy;

    // master = SPI byte driver plus register file; slave = the parser
    modport master (
        output cs_n, rec_data, rec_valid, reg_rdata,
        input  response_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
               cmd_err, busy
    );

    modport slave (
        input  cs_n, rec_data, rec_valid, reg_rdata,
        output response_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
               cmd_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_parser
// Brief    : Frames SPI bytes by cs_n, decodes write/read burst commands and
//            drives a simple register bus plus the next MISO response byte.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_parser #(
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter logic [7:0] CMD_WR      = 8'h01,
    parameter logic [7:0] CMD_RD      = 8'h02
) (
    input  logic           clk,
    input  logic           rst,
    spi_cmd_parser_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_WR = 3'd1,
        S_ADDR_RD = 3'd2,
        S_WDATA   = 3'd3,
        S_RDATA   = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_response;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_wr_en;
    logic              r_rd_en;
    logic              r_cmd_err;

    logic [7:0]        w_response_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_wdata_nxt;
    logic              w_wr_en_nxt;
    logic              w_rd_en_nxt;
    logic              w_cmd_err_nxt;

    logic [ADDR_W-1:0] w_rec_addr;
    logic [ADDR_W-1:0] w_addr_inc;

    generate
        if (ADDR_W > 8) begin : g_addr_wide
            assign w_rec_addr = {{(ADDR_W-8){1'b0}}, bus.rec_data};
        end else if (ADDR_W == 8) begin : g_addr_byte
            assign w_rec_addr = bus.rec_data;
        end else begin : g_addr_narrow
            assign w_rec_addr = bus.rec_data[ADDR_W-1:0];
        end
    endgenerate

    // Natural modulo-2^ADDR_W wrap, no error on overflow
    assign w_addr_inc = r_addr + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_response <= 8'h00;
            r_addr     <= '0;
            r_wdata    <= 8'h00;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_response <= w_response_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_cmd_err  <= w_cmd_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_response_nxt = r_response;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_wr_en_nxt    = 1'b0;
        w_rd_en_nxt    = 1'b0;
        w_cmd_err_nxt  = 1'b0;

        // A write strobe leaves the address in place for its own cycle, then advances
        if (r_wr_en) begin
            w_addr_nxt = w_addr_inc;
        end

        if (bus.rec_valid) begin
            case (r_state)
                S_IDLE: begin
                    w_response_nxt = STATUS_BYTE;
                    if (bus.rec_data == CMD_WR) begin
                        w_state_nxt = S_ADDR_WR;
                    end else if (bus.rec_data == CMD_RD) begin
                        w_state_nxt = S_ADDR_RD;
                    end else begin
                        w_state_nxt   = S_DISCARD;
                        w_cmd_err_nxt = 1'b1;
                    end
                end
                S_ADDR_WR: begin
                    w_addr_nxt     = w_rec_addr;
                    w_response_nxt = 8'h00;
                    w_state_nxt    = S_WDATA;
                end
                S_WDATA: begin
                    w_wdata_nxt = bus.rec_data;
                    w_wr_en_nxt = 1'b1;
                end
                S_ADDR_RD: begin
                    w_addr_nxt  = w_rec_addr;
                    w_rd_en_nxt = ~bus.cs_n;
                    w_state_nxt = S_RDATA;
                end
                S_RDATA: begin
                    w_addr_nxt  = w_addr_inc;
                    w_rd_en_nxt = ~bus.cs_n;
                end
                S_DISCARD: begin
                    w_response_nxt = STATUS_BYTE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // A read prefetch landing this cycle outranks the end-of-frame clear
        if (r_rd_en) begin
            w_response_nxt = bus.reg_rdata;
        end else if (bus.cs_n) begin
            w_response_nxt = 8'h00;
        end

        if (bus.cs_n) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign bus.response_data = r_response;
    assign bus.reg_addr      = r_addr;
    assign bus.reg_wdata     = r_wdata;
    assign bus.reg_wr_en     = r_wr_en;
    assign bus.reg_rd_en     = r_rd_en;
    assign bus.cmd_err       = r_cmd_err;
    assign bus.busy          = (r_state != S_IDLE);

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(r_wr_en && r_rd_en));

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_parser
// Brief    : Self-checking bench for spi_cmd_parser: directed frames followed by
//            random frames, compared against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_parser;

    localparam int         ADDR_W   = 8;
    localparam logic [7:0] C_STATUS = 8'hA5;
    localparam logic [7:0] C_WR     = 8'h01;
    localparam logic [7:0] C_RD     = 8'h02;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    spi_cmd_parser_if #(.ADDR_W(ADDR_W)) bus ();

    spi_cmd_parser #(
        .ADDR_W      (ADDR_W),
        .STATUS_BYTE (C_STATUS),
        .CMD_WR      (C_WR),
        .CMD_RD      (C_RD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file: read data presented while the read strobe is high, junk otherwise
    logic [7:0] mem       [256];
    logic [7:0] model_mem [256];
    logic [7:0] junk = 8'h00;

    assign bus.reg_rdata = bus.reg_rd_en ? mem[bus.reg_addr] : junk;

    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= model_mem[i];
        end else if (bus.reg_wr_en) begin
            mem[bus.reg_addr] <= bus.reg_wdata;
        end
    end

    logic [15:0] obs_wr [$];
    logic [7:0]  obs_rd [$];
    int          obs_err = 0;
    int          both_hi = 0;

    always @(negedge clk) begin
        if (bus.reg_wr_en) obs_wr.push_back({bus.reg_addr, bus.reg_wdata});
        if (bus.reg_rd_en) obs_rd.push_back(bus.reg_addr);
        if (bus.cmd_err) obs_err++;
        if (bus.reg_wr_en && bus.reg_rd_en) both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_cs,
                             output logic [7:0] resp, output logic busy_s, output logic err_s);
        @(posedge clk); #1;
        bus.rec_data  = b;
        bus.rec_valid = 1'b1;
        if (with_cs) bus.cs_n = 1'b1;
        @(posedge clk); #1;
        bus.rec_valid = 1'b0;
        bus.rec_data  = 8'($urandom);
        err_s = bus.cmd_err;
        @(posedge clk); #1;
        resp   = bus.response_data;
        busy_s = bus.busy;
        repeat ($urandom_range(3, 6)) @(posedge clk);
    endtask

    logic [7:0] frame [$];

    // Reference: derive expected strobes and per-byte responses from the frame bytes
    task automatic do_frame(input string name, input bit sim_last);
        int          n, wr_base, rd_base, err_base;
        logic [7:0]  cmd, a, er, resp;
        logic        busy_s, err_s;
        logic [15:0] exp_wr [$];
        logic [7:0]  exp_rd [$];
        bit          last, known;
        n        = frame.size();
        cmd      = frame[0];
        known    = (cmd == C_WR) || (cmd == C_RD);
        wr_base  = obs_wr.size();
        rd_base  = obs_rd.size();
        err_base = obs_err;
        a        = 8'h00;
        @(posedge clk); #1 bus.cs_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            last = sim_last && (k == n - 1);
            if (k == 0) begin
                er = C_STATUS;
            end else if (cmd == C_WR) begin
                if (k == 1) begin
                    a = frame[1];
                end else begin
                    exp_wr.push_back({a, frame[k]});
                    model_mem[a] = frame[k];
                    a = a + 8'd1;
                end
                er = 8'h00;
            end else if (cmd == C_RD) begin
                if (k == 1) a = frame[1];
                else        a = a + 8'd1;
                if (last) begin
                    er = 8'h00;
                end else begin
                    exp_rd.push_back(a);
                    er = model_mem[a];
                end
            end else begin
                er = C_STATUS;
            end
            if (last) er = 8'h00;
            send_byte(frame[k], last, resp, busy_s, err_s);
            if (k == 0) check({name, " cmd_err"}, err_s, !known);
            check($sformatf("%s resp[%0d]", name, k), resp, er);
            check($sformatf("%s busy[%0d]", name, k), busy_s, !last);
        end
        if (!sim_last) begin
            @(posedge clk); #1 bus.cs_n = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, " busy_end"}, bus.busy, 1'b0);
        check({name, " resp_end"}, bus.response_data, 8'h00);
        check({name, " n_wr"}, obs_wr.size() - wr_base, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && (wr_base + i) < obs_wr.size(); i++)
            check($sformatf("%s wr[%0d]", name, i), obs_wr[wr_base + i], exp_wr[i]);
        check({name, " n_rd"}, obs_rd.size() - rd_base, exp_rd.size());
        for (int i = 0; i < exp_rd.size() && (rd_base + i) < obs_rd.size(); i++)
            check($sformatf("%s rd[%0d]", name, i), obs_rd[rd_base + i], exp_rd[i]);
        check({name, " n_err"}, obs_err - err_base, known ? 0 : 1);
    endtask

    initial begin
        logic [7:0] resp;
        logic       busy_s, err_s;
        int         wr_base;
        logic [7:0] cmd;
        int         n;

        for (int i = 0; i < 256; i++) model_mem[i] = 8'($urandom);
        bus.cs_n      = 1'b1;
        bus.rec_valid = 1'b0;
        bus.rec_data  = 8'h00;

        #2 rst = 1'b1;
        #1;
        check("rst resp",  bus.response_data, 8'h00);
        check("rst addr",  bus.reg_addr, 8'h00);
        check("rst wdata", bus.reg_wdata, 8'h00);
        check("rst wr_en", bus.reg_wr_en, 1'b0);
        check("rst rd_en", bus.reg_rd_en, 1'b0);
        check("rst err",   bus.cmd_err, 1'b0);
        check("rst busy",  bus.busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        frame = {8'h01, 8'h10, 8'hAA, 8'hBB};  do_frame("wr_burst", 1'b0);
        frame = {8'h01, 8'h20, 8'h5C, 8'h3E};  do_frame("wr_setup", 1'b0);
        frame = {8'h02, 8'h20, 8'($urandom), 8'($urandom)};  do_frame("rd_burst", 1'b0);
        frame = {8'h7F, 8'h10, 8'h55};         do_frame("bad_cmd", 1'b0);
        frame = {8'h01, 8'hFF, 8'h11, 8'h22};  do_frame("wrap", 1'b0);
        frame = {8'h01, 8'h30, 8'h44, 8'h66};  do_frame("sim_cs", 1'b1);
        frame = {8'h02, 8'h30, 8'($urandom)};  do_frame("after_sim", 1'b0);

        // Reset during a write burst
        @(posedge clk); #1 bus.cs_n = 1'b0;
        send_byte(8'h01, 1'b0, resp, busy_s, err_s);
        send_byte(8'h40, 1'b0, resp, busy_s, err_s);
        send_byte(8'h12, 1'b0, resp, busy_s, err_s);
        model_mem[8'h40] = 8'h12;
        @(posedge clk); #1;
        bus.rec_data  = 8'h34;
        bus.rec_valid = 1'b1;
        @(posedge clk); #1;
        bus.rec_valid = 1'b0;
        check("mid wr_en_pre", bus.reg_wr_en, 1'b1);
        rst = 1'b1;
        #1;
        check("mid resp",  bus.response_data, 8'h00);
        check("mid addr",  bus.reg_addr, 8'h00);
        check("mid wdata", bus.reg_wdata, 8'h00);
        check("mid wr_en", bus.reg_wr_en, 1'b0);
        check("mid rd_en", bus.reg_rd_en, 1'b0);
        check("mid err",   bus.cmd_err, 1'b0);
        check("mid busy",  bus.busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        wr_base = obs_wr.size();
        send_byte(8'h55, 1'b0, resp, busy_s, err_s);
        check("mid resp_after", resp, C_STATUS);
        repeat (6) @(posedge clk);
        #1;
        check("mid no_wr", obs_wr.size() - wr_base, 0);
        bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: cmd = C_WR;
                4, 5, 6, 7: cmd = C_RD;
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == C_WR || cmd == C_RD) cmd = 8'($urandom);
                end
            endcase
            n = $urandom_range(1, 6);
            frame = {cmd};
            for (int k = 1; k < n; k++) frame.push_back(8'($urandom));
            do_frame($sformatf("rnd%0d", f),
                     (cmd == C_WR) && (n >= 3) && ($urandom_range(0, 3) == 0));
        end

        check("strobe_excl", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
